// File: rtl/alu_wb_queue_if.sv
// alu_wb_queue_if: bundles the ALU-result enqueue ports, the register-file
// writeback handshake and the forwarding lookup of alu_wb_queue.
//   master : the environment (ALU pair, register file, issue stage)
//   slave  : the queue itself
//
// Handshakes:
//   enqueue   - a slot with inN_valid=1 is taken on a clk edge only when
//               in_ready=1. When in_ready=0 the producer must hold both slots.
//   writeback - the head moves to the register file on an edge where
//               wb_valid=1 and wb_ready=1. wb_rd/wb_data stay stable while
//               wb_valid=1 and wb_ready=0.
interface alu_wb_queue_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in0_valid;
  logic [RD_W-1:0]   in0_rd;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid;
  logic [RD_W-1:0]   in1_rd;
  logic [DATA_W-1:0] in1_data;
  logic              in_ready;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic [RD_W-1:0]   fwd_rd;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in0_valid, in0_rd, in0_data, in1_valid, in1_rd, in1_data,
    output wb_ready, fwd_rd,
    input  in_ready, wb_valid, wb_rd, wb_data, fwd_hit, fwd_data
  );

  modport slave (
    input  in0_valid, in0_rd, in0_data, in1_valid, in1_rd, in1_data,
    input  wb_ready, fwd_rd,
    output in_ready, wb_valid, wb_rd, wb_data, fwd_hit, fwd_data
  );
endinterface

// File: rtl/alu_wb_queue.sv
// alu_wb_queue: writeback queue between the dual ALU execute stage and the
// single register-file write port. Takes up to two results per cycle (slot 0
// older than slot 1), keeps them in program order in a circular FIFO and
// drains one per cycle. A forwarding lookup returns the youngest queued value
// for a destination register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (clears pointers, count and storage)
//   flush - synchronous clear of all entries (pointers and count only)
//   bus   - alu_wb_queue_if.slave: in0/in1 slots, in_ready, wb_* handshake,
//           fwd_rd lookup with fwd_hit/fwd_data
//   count - number of occupied entries
module alu_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  alu_wb_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [RD_W-1:0]   rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic              in_ready;
  logic              acc0;
  logic              acc1;
  logic              deq;
  logic [1:0]        enq_n;
  logic [PW-1:0]     wr_idx1;

  // in_ready looks only at the registered count so that a full cycle always
  // has room for two results, independent of a same-cycle dequeue.
  assign in_ready = (count <= CW'(DEPTH - 2));
  // Results for x0 are dropped: the register is hardwired to zero.
  assign acc0     = bus.in0_valid && in_ready && (bus.in0_rd != '0);
  assign acc1     = bus.in1_valid && in_ready && (bus.in1_rd != '0);
  assign enq_n    = {1'b0, acc0} + {1'b0, acc1};
  assign deq      = bus.wb_valid && bus.wb_ready;
  // Slot 1 goes right after slot 0 when both land, otherwise at tail.
  assign wr_idx1  = acc0 ? (tail + PW'(1)) : tail;

  assign bus.in_ready = in_ready;
  assign bus.wb_valid = (count != '0);
  assign bus.wb_rd    = rd_mem[head];
  assign bus.wb_data  = data_mem[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (flush) begin
      // Same-cycle enqueue and dequeue are discarded.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (acc0) begin
        rd_mem[tail]   <= bus.in0_rd;
        data_mem[tail] <= bus.in0_data;
      end
      if (acc1) begin
        rd_mem[wr_idx1]   <= bus.in1_rd;
        data_mem[wr_idx1] <= bus.in1_data;
      end
      tail  <= tail + PW'(enq_n);
      head  <= head + PW'(deq);
      count <= count + CW'(enq_n) - CW'(deq);
    end
  end

  // Forwarding: walk occupied entries oldest-to-youngest (offset i back from
  // tail-1, largest offset first) so the youngest match is the last to write.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = tail - PW'(i) - PW'(1);
      if ((CW'(i) < count) && (bus.fwd_rd != '0) && (rd_mem[idx] == bus.fwd_rd)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_mem[idx];
      end
    end
  end
endmodule

// File: doc/alu_wb_queue.md
# alu_wb_queue

Writeback queue between the dual ALU execute stage and the register-file write port. Each cycle it accepts up to two ALU results (slot 0 older than slot 1), buffers them in program order in a small circular FIFO, and drains one result per cycle to the single register-file write port over a valid/ready handshake. It also offers a forwarding lookup: the issue stage can read the youngest still-queued value for any destination register.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- DATA_W, 32: result width; matches ALU R.
- RD_W, 5: destination register index width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- in0_valid  in  1  slot 0 result valid.
- in0_rd  in  RD_W  slot 0 destination register.
- in0_data  in  DATA_W  slot 0 result.
- in1_valid  in  1  slot 1 result valid; slot 1 is younger than slot 0.
- in1_rd  in  RD_W  slot 1 destination register.
- in1_data  in  DATA_W  slot 1 result.
- in_ready  out  1  queue can take two results this cycle.
- wb_valid  out  1  head entry present.
- wb_rd  out  RD_W  head destination register.
- wb_data  out  DATA_W  head result.
- wb_ready  in  1  register file consumes the head this cycle.
- fwd_rd  in  RD_W  forwarding lookup register.
- fwd_hit  out  1  a queued entry matches fwd_rd.
- fwd_data  out  DATA_W  data from the youngest matching entry.
- count  out  clog2(DEPTH)+1  number of occupied entries.

## Operation
- **Storage.** Circular buffer of {rd, data} with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- **in_ready.** Equals (count ≤ DEPTH−2), evaluated on the registered count. A dequeue in the same cycle does not raise in_ready.
- **Enqueue.** A slot is accepted when its valid and in_ready are both high.
  - Accepted slots with rd ≠ 0 are written at tail, then tail+1, with slot 0 first.
  - A single valid slot, whether 0 or 1, is written at tail.
  - Slots with rd = 0 are dropped and not counted, because x0 is hardwired.
  - When in_ready is low, both slots are ignored and the producer must hold them.
- **Dequeue.** Fires when wb_valid and wb_ready are both high; head advances by 1.
  - wb_valid = (count ≠ 0).
  - wb_rd and wb_data are read combinationally from storage[head].
- **Count update.** count_next = count + enq_n − deq. Here enq_n ∈ {0,1,2}. Enqueue and dequeue in the same cycle are both applied.
- **Forwarding.** Combinational search over the occupied entries, from tail−1 back to head.
  - The first match on rd == fwd_rd wins and supplies fwd_data.
  - fwd_rd = 0 always gives fwd_hit = 0.
  - Incoming same-cycle results are not searched.
  - When there is no hit, fwd_data = 0.
- **Priority.** rst_n low, then flush, then normal operation.
  - Flush sets head = tail = count = 0.
  - Flush discards any same-cycle enqueue or dequeue. A dequeue is not counted as consumed even if wb_ready was high.
- **Reset.** Applies at the next clk edge while rst_n = 0. It is legal mid-operation and all entries are lost.
  - Output values after reset: count = 0, wb_valid = 0, in_ready = 1, fwd_hit = 0, wb_rd = 0, wb_data = 0, fwd_data = 0.
  - Storage is cleared on reset.

## Timing
- **Result latency.** An enqueue at edge N becomes visible on wb_* and in forwarding from cycle N+1. Minimum result-to-writeback latency is 1 cycle.
- **Throughput.** Drain rate is 1 result/cycle. Fill rate is up to 2 results/cycle while in_ready is high.
- **wb_* stability.** wb_* stay stable while wb_valid = 1 and wb_ready = 0. The head changes only on a dequeue edge.
- **in_ready transitions.**
  - With DEPTH=4, in_ready falls on the edge where count reaches 3.
  - It rises on the first edge where count drops to ≤2.
- **Full/empty boundaries.**
  - count never exceeds DEPTH, because in_ready guarantees room for 2.
  - Dequeue when count = 0 is impossible, since wb_valid = 0.
- **Wrap-around.** A two-slot enqueue with tail = DEPTH−1 writes entries DEPTH−1 and 0.

## Test plan
- **Reset values.** Hold rst_n=0 for 2 cycles with random inputs, then release → count=0, wb_valid=0, in_ready=1, fwd_hit=0.
- **Ordering.** Cycle 1: in0={rd 3, 0x11}, in1={rd 4, 0x22}, wb_ready=0.
  - Then hold wb_ready=1 → wb shows (3, 0x11) first and (4, 0x22) next cycle; count goes 2→1→0.
- **x0 drop and single slot.**
  - in0={rd 0, 0xFF} with in1={rd 7, 0x5} → only (7, 0x5) is queued; count=1.
  - in1 valid alone is likewise accepted.
- **Full and wrap-around.** Four back-to-back dual enqueues with wb_ready=1 every cycle.
  - Required: in_ready drops at count=3; the producer stalls; pointer wrap preserves FIFO order across 8 results with distinct data.
- **Forwarding youngest match.** Queue (5, 0xA), (5, 0xB), (6, 0xC), with wb_ready=0.
  - fwd_rd=5 → fwd_hit=1, fwd_data=0xB.
  - fwd_rd=9 → fwd_hit=0, fwd_data=0.
  - fwd_rd=0 → fwd_hit=0.
- **Flush and mid-operation reset.**
  - With count=3, assert flush together with a dual enqueue and wb_ready=1 → next cycle count=0, wb_valid=0, in_ready=1.
  - Repeat with rst_n=0 instead of flush → same result.
